// File: rtl/hcordic_pkg.sv
// Shared HCORDIC types: word widths, mode encodings and the packed instruction word.
package hcordic_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned TAG_W  = 8;
  localparam int unsigned MODE_W = 2;

  // CORDIC coordinate system carried in the mode field
  localparam logic [MODE_W-1:0] MODE_LIN  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_CIRC = 2'b01;
  localparam logic [MODE_W-1:0] MODE_HYP  = 2'b11;

  // Tag value that marks an empty issue slot
  localparam logic [TAG_W-1:0] BUBBLE_TAG = '0;

  // One instruction word as it travels through the pipeline
  typedef struct packed {
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [WIDTH-1:0]  z;
    logic [WIDTH-1:0]  k;
    logic [MODE_W-1:0] mode;
    logic              operation;
    logic              natlog;
    logic [TAG_W-1:0]  tag;
  } instr_t;

  // Issue-slot source chosen by the arbiter each cycle
  typedef enum logic [1:0] {
    SEL_IDLE = 2'b00,
    SEL_FB   = 2'b01,
    SEL_NEW  = 2'b10
  } sel_e;

endpackage

// File: rtl/cordic_issue_mux_if.sv
// Bundle of the new-instruction, feedback, issue and retire signals of the issue mux.
interface cordic_issue_mux_if #(
  parameter int unsigned WIDTH = hcordic_pkg::WIDTH,
  parameter int unsigned TAG_W = hcordic_pkg::TAG_W
);

  // New instruction side
  logic [WIDTH-1:0]              x_in, y_in, z_in, k_in;
  logic [hcordic_pkg::MODE_W-1:0] mode_in;
  logic                          operation_in;
  logic                          NatLogFlag_in;
  logic [TAG_W-1:0]              InsTag_in;
  logic                          in_valid;
  logic                          in_ready;

  // Feedback from the iteration stage
  logic [WIDTH-1:0]              x_fb, y_fb, z_fb, k_fb;
  logic [hcordic_pkg::MODE_W-1:0] mode_fb;
  logic                          operation_fb;
  logic                          NatLogFlag_fb;
  logic [TAG_W-1:0]              InsTag_fb;
  logic                          fb_valid;
  logic                          fb_done;

  // Issue towards the FSM stage
  logic [WIDTH-1:0]              xout_Mux, yout_Mux, zout_Mux, kout_Mux;
  logic [hcordic_pkg::MODE_W-1:0] modeout_Mux;
  logic                          operationout_Mux;
  logic                          NatLogFlagout_Mux;
  logic [TAG_W-1:0]              InsTagMuxOut;
  logic                          validout_Mux;

  // Retired results
  logic [WIDTH-1:0]              xres, yres, zres, kres;
  logic [TAG_W-1:0]              InsTagRes;
  logic                          res_valid;

  // Issue mux side
  modport slave (
    input  x_in, y_in, z_in, k_in, mode_in, operation_in, NatLogFlag_in, InsTag_in, in_valid,
    output in_ready,
    input  x_fb, y_fb, z_fb, k_fb, mode_fb, operation_fb, NatLogFlag_fb, InsTag_fb,
    input  fb_valid, fb_done,
    output xout_Mux, yout_Mux, zout_Mux, kout_Mux, modeout_Mux, operationout_Mux,
    output NatLogFlagout_Mux, InsTagMuxOut, validout_Mux,
    output xres, yres, zres, kres, InsTagRes, res_valid
  );

  // Surrounding pipeline side
  modport master (
    output x_in, y_in, z_in, k_in, mode_in, operation_in, NatLogFlag_in, InsTag_in, in_valid,
    input  in_ready,
    output x_fb, y_fb, z_fb, k_fb, mode_fb, operation_fb, NatLogFlag_fb, InsTag_fb,
    output fb_valid, fb_done,
    input  xout_Mux, yout_Mux, zout_Mux, kout_Mux, modeout_Mux, operationout_Mux,
    input  NatLogFlagout_Mux, InsTagMuxOut, validout_Mux,
    input  xres, yres, zres, kres, InsTagRes, res_valid
  );

endinterface

// File: rtl/cordic_issue_mux_issue_fifo.sv
// Small synchronous FIFO of instruction words; head is visible combinationally.
module issue_fifo
  import hcordic_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  instr_t wdata,
  input  logic   pop,
  output instr_t rdata_c,
  output logic   empty_c,
  output logic   can_push
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt_c;
  logic             do_push_c;
  logic             do_pop_c;

  // Qualify requests and derive the next occupancy
  always_comb begin
    do_push_c   = push & can_push;
    do_pop_c    = pop & (count != '0);
    count_nxt_c = count;
    if (do_push_c && !do_pop_c) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (!do_push_c && do_pop_c) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  assign empty_c = (count == '0);
  assign rdata_c = mem[rd_ptr];

  // Pointers, occupancy and the registered not-full flag; pointers wrap on power-of-two depth
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      can_push <= 1'b0;
    end else begin
      if (do_push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_nxt_c;
      can_push <= (count_nxt_c != FULL_CNT);
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clock) begin
    if (do_push_c) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/cordic_issue_mux.sv
// HCORDIC issue stage: buffers new instructions, gives recirculating words priority,
// issues one word per cycle and retires converged feedback words to the result port.
module cordic_issue_mux #(
  parameter int unsigned WIDTH = hcordic_pkg::WIDTH,
  parameter int unsigned TAG_W = hcordic_pkg::TAG_W,
  parameter int unsigned DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  cordic_issue_mux_if.slave bus
);

  import hcordic_pkg::instr_t;
  import hcordic_pkg::sel_e;
  import hcordic_pkg::SEL_IDLE;
  import hcordic_pkg::SEL_FB;
  import hcordic_pkg::SEL_NEW;
  import hcordic_pkg::BUBBLE_TAG;

  instr_t new_word_c;
  instr_t fb_word_c;
  instr_t head_c;
  logic   fifo_empty_c;
  logic   fifo_can_push;
  logic   push_c;
  logic   pop_c;
  logic   retire_c;
  sel_e   sel_c;

  instr_t issue_q;
  logic   issue_valid_q;
  instr_t res_q;
  logic   res_valid_q;

  // Pack both incoming word sources
  always_comb begin
    new_word_c           = '0;
    new_word_c.x         = bus.x_in[WIDTH-1:0];
    new_word_c.y         = bus.y_in[WIDTH-1:0];
    new_word_c.z         = bus.z_in[WIDTH-1:0];
    new_word_c.k         = bus.k_in[WIDTH-1:0];
    new_word_c.mode      = bus.mode_in;
    new_word_c.operation = bus.operation_in;
    new_word_c.natlog    = bus.NatLogFlag_in;
    new_word_c.tag       = bus.InsTag_in[TAG_W-1:0];

    fb_word_c            = '0;
    fb_word_c.x          = bus.x_fb[WIDTH-1:0];
    fb_word_c.y          = bus.y_fb[WIDTH-1:0];
    fb_word_c.z          = bus.z_fb[WIDTH-1:0];
    fb_word_c.k          = bus.k_fb[WIDTH-1:0];
    fb_word_c.mode       = bus.mode_fb;
    fb_word_c.operation  = bus.operation_fb;
    fb_word_c.natlog     = bus.NatLogFlag_fb;
    fb_word_c.tag        = bus.InsTag_fb[TAG_W-1:0];
  end

  // Arbitration: live feedback cannot stall, so it always takes the slot
  always_comb begin
    sel_c    = SEL_IDLE;
    retire_c = bus.fb_valid & bus.fb_done;
    if (bus.fb_valid && !bus.fb_done) begin
      sel_c = SEL_FB;
    end else if (!fifo_empty_c) begin
      sel_c = SEL_NEW;
    end
    pop_c  = (sel_c == SEL_NEW);
    push_c = bus.in_valid & fifo_can_push;
  end

  issue_fifo #(
    .DEPTH(DEPTH)
  ) u_issue_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_c),
    .wdata   (new_word_c),
    .pop     (pop_c),
    .rdata_c (head_c),
    .empty_c (fifo_empty_c),
    .can_push(fifo_can_push)
  );

  // Issue register; a bubble clears valid and tag but keeps the last data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      case (sel_c)
        SEL_FB: begin
          issue_q       <= fb_word_c;
          issue_valid_q <= 1'b1;
        end
        SEL_NEW: begin
          issue_q       <= head_c;
          issue_valid_q <= 1'b1;
        end
        default: begin
          issue_q.tag   <= BUBBLE_TAG;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Retire register; res_valid pulses for one cycle per converged word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= retire_c;
      if (retire_c) begin
        res_q <= fb_word_c;
      end
    end
  end

  assign bus.in_ready          = fifo_can_push;
  assign bus.xout_Mux          = issue_q.x;
  assign bus.yout_Mux          = issue_q.y;
  assign bus.zout_Mux          = issue_q.z;
  assign bus.kout_Mux          = issue_q.k;
  assign bus.modeout_Mux       = issue_q.mode;
  assign bus.operationout_Mux  = issue_q.operation;
  assign bus.NatLogFlagout_Mux = issue_q.natlog;
  assign bus.InsTagMuxOut      = issue_q.tag;
  assign bus.validout_Mux      = issue_valid_q;
  assign bus.xres              = res_q.x;
  assign bus.yres              = res_q.y;
  assign bus.zres              = res_q.z;
  assign bus.kres              = res_q.k;
  assign bus.InsTagRes         = res_q.tag;
  assign bus.res_valid         = res_valid_q;

endmodule

// File: tb/tb_cordic_issue_mux.sv
// Directed, table-driven bench for the HCORDIC issue mux.
module tb_cordic_issue_mux;
  import hcordic_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  cordic_issue_mux_if #(.WIDTH(32), .TAG_W(8)) bus ();

  cordic_issue_mux #(
    .WIDTH(32),
    .TAG_W(8),
    .DEPTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [31:0] k;
    logic [7:0]  tag;
  } res_t;

  typedef struct {
    logic       iv;
    logic [7:0] itag;
    logic       fv;
    logic       fd;
    logic [7:0] ftag;
    logic       ev;
    logic       esrc_fb;
    logic [7:0] etag;
    logic       erv;
    logic [7:0] ertag;
    logic       erdy;
  } vec_t;

  localparam int NVEC = 14;
  vec_t   vt [NVEC];
  instr_t exp_issue;

  function automatic instr_t mk_new(input logic [7:0] t);
    instr_t w;
    w.x         = {24'h3F8000, t};
    w.y         = {24'hC0A000, t};
    w.z         = {24'h00ABCD, t};
    w.k         = {24'h3F1B74, t};
    w.mode      = t[1:0];
    w.operation = t[2];
    w.natlog    = t[3];
    w.tag       = t;
    return w;
  endfunction

  function automatic instr_t mk_fb(input logic [7:0] t);
    instr_t w;
    w.x         = {24'h404900, t};
    w.y         = {24'hBF8000, t};
    w.z         = {24'h3E8000, t};
    w.k         = {24'h3F9B00, t};
    w.mode      = ~t[1:0];
    w.operation = ~t[2];
    w.natlog    = ~t[3];
    w.tag       = t;
    return w;
  endfunction

  function automatic res_t res_of(input instr_t w);
    res_t r;
    r.x = w.x; r.y = w.y; r.z = w.z; r.k = w.k; r.tag = w.tag;
    return r;
  endfunction

  function automatic instr_t get_issue();
    instr_t w;
    w.x         = bus.xout_Mux;
    w.y         = bus.yout_Mux;
    w.z         = bus.zout_Mux;
    w.k         = bus.kout_Mux;
    w.mode      = bus.modeout_Mux;
    w.operation = bus.operationout_Mux;
    w.natlog    = bus.NatLogFlagout_Mux;
    w.tag       = bus.InsTagMuxOut;
    return w;
  endfunction

  function automatic res_t get_res();
    res_t r;
    r.x = bus.xres; r.y = bus.yres; r.z = bus.zres; r.k = bus.kres; r.tag = bus.InsTagRes;
    return r;
  endfunction

  task automatic drive_new(input instr_t w, input logic v);
    bus.x_in          = w.x;
    bus.y_in          = w.y;
    bus.z_in          = w.z;
    bus.k_in          = w.k;
    bus.mode_in       = w.mode;
    bus.operation_in  = w.operation;
    bus.NatLogFlag_in = w.natlog;
    bus.InsTag_in     = w.tag;
    bus.in_valid      = v;
  endtask

  task automatic drive_fb(input instr_t w, input logic v, input logic d);
    bus.x_fb          = w.x;
    bus.y_fb          = w.y;
    bus.z_fb          = w.z;
    bus.k_fb          = w.k;
    bus.mode_fb       = w.mode;
    bus.operation_fb  = w.operation;
    bus.NatLogFlag_fb = w.natlog;
    bus.InsTag_fb     = w.tag;
    bus.fb_valid      = v;
    bus.fb_done       = d;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input instr_t act, input instr_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input res_t act, input res_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t w;
    int     got;

    n_checks = 0;
    n_errors = 0;

    //            iv    itag   fv    fd    ftag   ev    fb    etag   erv   ertag  rdy
    vt[0]  = '{1'b1, 8'h31, 1'b1, 1'b0, 8'hF1, 1'b1, 1'b1, 8'hF1, 1'b0, 8'h00, 1'b1};
    vt[1]  = '{1'b1, 8'h32, 1'b1, 1'b0, 8'hF2, 1'b1, 1'b1, 8'hF2, 1'b0, 8'h00, 1'b1};
    vt[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'hF3, 1'b1, 1'b1, 8'hF3, 1'b0, 8'h00, 1'b1};
    vt[3]  = '{1'b1, 8'h34, 1'b1, 1'b0, 8'hF4, 1'b1, 1'b1, 8'hF4, 1'b0, 8'h00, 1'b0};
    vt[4]  = '{1'b1, 8'h35, 1'b1, 1'b0, 8'hF5, 1'b1, 1'b1, 8'hF5, 1'b0, 8'h00, 1'b0};
    vt[5]  = '{1'b1, 8'h36, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h31, 1'b0, 8'h00, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h32, 1'b0, 8'h00, 1'b1};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 8'h33, 1'b1, 8'h22, 1'b1};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h34, 1'b0, 8'h00, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h23, 1'b0, 1'b0, 8'h00, 1'b1, 8'h23, 1'b1};
    vt[11] = '{1'b1, 8'h40, 1'b1, 1'b0, 8'h24, 1'b1, 1'b1, 8'h24, 1'b0, 8'h00, 1'b1};
    vt[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h25, 1'b1, 1'b0, 8'h40, 1'b1, 8'h25, 1'b1};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};

    // Reset state
    reset = 1'b1;
    drive_new('0, 1'b0);
    drive_fb('0, 1'b0, 1'b0);
    step();
    step();
    chk("reset validout", 64'(bus.validout_Mux), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset res_valid", 64'(bus.res_valid), 64'd0);
    chk_word("reset issue word", get_issue(), '0);
    reset = 1'b0;
    step();
    chk("in_ready after reset", 64'(bus.in_ready), 64'd1);

    // First push issues two edges later, never on the push edge
    w   = mk_new(8'h11);
    w.x = 32'h3F800000;
    drive_new(w, 1'b1);
    step();
    drive_new('0, 1'b0);
    chk("no bypass validout", 64'(bus.validout_Mux), 64'd0);
    step();
    chk("first issue valid", 64'(bus.validout_Mux), 64'd1);
    chk("first issue tag", 64'(bus.InsTagMuxOut), 64'h11);
    chk("first issue x", 64'(bus.xout_Mux), 64'h3F800000);
    chk_word("first issue word", get_issue(), w);
    exp_issue = w;

    // Cycle-by-cycle vectors: fill under feedback, full pop, retire alongside issue, idle holds
    for (int i = 0; i < NVEC; i++) begin
      drive_new(mk_new(vt[i].itag), vt[i].iv);
      drive_fb(mk_fb(vt[i].ftag), vt[i].fv, vt[i].fd);
      step();
      if (vt[i].ev) begin
        exp_issue = vt[i].esrc_fb ? mk_fb(vt[i].etag) : mk_new(vt[i].etag);
      end else begin
        exp_issue.tag = 8'h00;
      end
      chk($sformatf("vec%0d validout", i), 64'(bus.validout_Mux), 64'(vt[i].ev));
      chk_word($sformatf("vec%0d issue", i), get_issue(), exp_issue);
      chk($sformatf("vec%0d res_valid", i), 64'(bus.res_valid), 64'(vt[i].erv));
      if (vt[i].erv) begin
        chk_res($sformatf("vec%0d result", i), get_res(), res_of(mk_fb(vt[i].ertag)));
      end
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(vt[i].erdy));
    end

    // Twelve words streamed through the four-entry FIFO, pointers wrap three times
    got = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 12) drive_new(mk_new(8'(8'h50 + i)), 1'b1);
      else        drive_new('0, 1'b0);
      drive_fb('0, 1'b0, 1'b0);
      step();
      if (bus.validout_Mux) begin
        if (got < 12) begin
          chk_word($sformatf("stream word %0d", got), get_issue(), mk_new(8'(8'h50 + got)));
        end
        got++;
      end
    end
    chk("stream issue count", 64'(got), 64'd12);

    // Async reset in the middle of traffic with buffered words and a pending retire
    for (int i = 0; i < 3; i++) begin
      drive_new(mk_new(8'(8'h61 + i)), 1'b1);
      drive_fb(mk_fb(8'(8'h71 + i)), 1'b1, 1'b0);
      step();
    end
    drive_new(mk_new(8'h64), 1'b1);
    drive_fb(mk_fb(8'h74), 1'b1, 1'b1);
    step();
    chk("pre-reset res_valid", 64'(bus.res_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset validout", 64'(bus.validout_Mux), 64'd0);
    chk_word("async reset issue word", get_issue(), '0);
    chk("async reset res_valid", 64'(bus.res_valid), 64'd0);
    chk_res("async reset result", get_res(), '0);
    chk("async reset in_ready", 64'(bus.in_ready), 64'd0);
    step();
    step();
    drive_new('0, 1'b0);
    drive_fb('0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("post-reset%0d validout", i), 64'(bus.validout_Mux), 64'd0);
      chk($sformatf("post-reset%0d tag", i), 64'(bus.InsTagMuxOut), 64'd0);
      chk($sformatf("post-reset%0d res_valid", i), 64'(bus.res_valid), 64'd0);
    end
    drive_new(mk_new(8'h65), 1'b1);
    step();
    drive_new('0, 1'b0);
    step();
    chk("post-reset issue valid", 64'(bus.validout_Mux), 64'd1);
    chk_word("post-reset issue word", get_issue(), mk_new(8'h65));
    step();
    chk("post-reset drained", 64'(bus.validout_Mux), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
